// File: rtl/hs_update_ctrl.sv
// hs_update_ctrl: inserts a new score into a descending-sorted score table
// held in an external RAM. The table is read into a local copy, the insertion
// rank is found, lower entries are shifted down one slot bottom-up and the new
// score is written. done_wr pulses once after the last write so the RAM can
// persist the table; it never pulses when the table is left unchanged.
// A reset in the middle of a shift does not undo writes already issued, so
// the table may be left partially shifted.
// All outputs are registered and decoded from next-state values, so there is
// no combinational path from any input to any output.
module hs_update_ctrl #(
  parameter int N_ENTRIES = 3,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] new_score,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done_wr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rank
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CMP   = 3'd2,
    S_WRITE = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] NOT_PLACED = ADDR_W'(N_ENTRIES);

  // Lowest index whose stored score is strictly below the candidate; ties keep
  // the older entry ahead. Returns NOT_PLACED when the candidate ranks nowhere.
  function automatic logic [ADDR_W-1:0] find_rank(
    input logic [DATA_W-1:0] cand,
    input logic [DATA_W-1:0] tbl [N_ENTRIES]
  );
    logic [ADDR_W-1:0] k;
    k = NOT_PLACED;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      k = (cand > tbl[i]) ? ADDR_W'(i) : k;
    end
    return k;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] score_q, score_d;
  logic [DATA_W-1:0] tbl_q [N_ENTRIES];
  logic [DATA_W-1:0] tbl_d [N_ENTRIES];
  logic [ADDR_W-1:0] rank_q, rank_d;
  logic [ADDR_W-1:0] k_s;

  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_wr_q, done_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Insertion rank of the captured score against the local table copy.
  always_comb begin
    k_s = find_rank(score_q, tbl_q);
  end

  // Next-state, counter, table-copy and rank sequencing.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    score_d = score_q;
    tbl_d   = tbl_q;
    rank_d  = rank_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          score_d = new_score;
          rcnt_d  = {ADDR_W{1'b0}};
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        tbl_d[rcnt_q] = rd_data;
        if (rcnt_q == LAST_A) begin
          state_d = S_CMP;
        end else begin
          rcnt_d = rcnt_q + ONE_A;
        end
      end
      S_CMP: begin
        rank_d = k_s;
        if (k_s == NOT_PLACED) begin
          state_d = S_DONE;
        end else begin
          wcnt_d  = LAST_A;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Bottom-up shift: the slot being written has already been copied.
        if (wcnt_q == rank_q) begin
          state_d = S_FLUSH;
        end else begin
          wcnt_d = wcnt_q - ONE_A;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from next-state values so the outputs come straight off flops.
  always_comb begin
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = {ADDR_W{1'b0}};
    wr_data_d = {DATA_W{1'b0}};
    done_wr_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = 1'b0;
    case (state_d)
      S_READ: begin
        cs_d   = 1'b1;
        addr_d = rcnt_d;
      end
      S_WRITE: begin
        cs_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = wcnt_d;
        if (wcnt_d == rank_d) begin
          wr_data_d = score_d;
        end else if (wcnt_d != {ADDR_W{1'b0}}) begin
          wr_data_d = tbl_d[wcnt_d - ONE_A];
        end else begin
          wr_data_d = {DATA_W{1'b0}};
        end
      end
      S_FLUSH: begin
        done_wr_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rcnt_q    <= {ADDR_W{1'b0}};
      wcnt_q    <= {ADDR_W{1'b0}};
      score_q   <= {DATA_W{1'b0}};
      tbl_q     <= '{default: {DATA_W{1'b0}}};
      rank_q    <= {ADDR_W{1'b0}};
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      done_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      score_q   <= score_d;
      tbl_q     <= tbl_d;
      rank_q    <= rank_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      done_wr_q <= done_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cs      = cs_q;
  assign we      = we_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign done_wr = done_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rank    = rank_q;

endmodule

// File: tb/tb_hs_update_ctrl.sv
// Bench for hs_update_ctrl: behavioural score RAM, a reference table model
// and a scoreboard of expected writes and completions.
module tb_hs_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] new_score;
  logic [31:0] rd_data;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic        done_wr;
  logic        busy;
  logic        done;
  logic [1:0]  rank;

  hs_update_ctrl #(.N_ENTRIES(3), .DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .new_score(new_score),
    .rd_data(rd_data), .cs(cs), .we(we), .addr(addr), .wr_data(wr_data),
    .done_wr(done_wr), .busy(busy), .done(done), .rank(rank)
  );

  always #5 clk = ~clk;

  // Score RAM: combinational read, write on posedge.
  logic [31:0] mem [4] = '{32'd900, 32'd500, 32'd100, 32'd0};
  assign rd_data = mem[addr];
  always @(posedge clk) begin
    if (cs && we) mem[addr] <= wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [1:0] rank; int cyc; int dwr; logic [31:0] t0, t1, t2; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  logic [31:0] model [3] = '{32'd900, 32'd500, 32'd100};

  int checks = 0;
  int errors = 0;
  int dwr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: rank, write sequence, latency and resulting table.
  task automatic push_run(input logic [31:0] v, input int e, output int lat);
    int k;
    wr_t w;
    dn_t x;
    logic [31:0] nt [3];
    k = 3;
    for (int i = 2; i >= 0; i--) if (v > model[i]) k = i;
    nt = model;
    if (k < 3) begin
      for (int j = 2; j >= k; j--) begin
        w.a = 2'(j);
        if (j == k) w.d = v;
        else        w.d = model[j-1];
        nt[j] = w.d;
        wq.push_back(w);
      end
    end
    lat = (k == 3) ? 5 : 6 + (3 - k);
    model = nt;
    x.rank = 2'(k);
    x.cyc  = e + lat - 1;
    x.dwr  = (k < 3) ? 1 : 0;
    x.t0 = nt[0]; x.t1 = nt[1]; x.t2 = nt[2];
    dq.push_back(x);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    dn_t x;
    if (reset === 1'b1) begin
      dwr_cnt = 0;
    end else begin
      if (cs === 1'b1 && we === 1'b1) begin
        if (wq.size() == 0) chk("spurious_write", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(addr), 32'(w.a));
          chk("wr_data", wr_data, w.d);
        end
      end
      if (done_wr === 1'b1) dwr_cnt++;
      if (done === 1'b1) begin
        if (dq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          x = dq.pop_front();
          chk("rank", 32'(rank), 32'(x.rank));
          chk("done_cycle", 32'(cyc), 32'(x.cyc));
          chk("done_wr_count", 32'(dwr_cnt), 32'(x.dwr));
          chk("done_cs", 32'(cs), 32'd0);
          chk("tbl0", mem[0], x.t0);
          chk("tbl1", mem[1], x.t1);
          chk("tbl2", mem[2], x.t2);
        end
        dwr_cnt = 0;
      end
    end
  end

  task automatic go(input logic [31:0] v);
    int e, lat;
    @(negedge clk);
    new_score = v;
    start = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    start = 1'b0;
    push_run(v, e, lat);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((dq.size() != 0 || busy === 1'b1) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("run_bound", 32'(n < 60), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e1, e2, l1, l2, n;
    wr_t w;
    reset = 1'b1;
    start = 1'b0;
    new_score = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_done_wr", 32'(done_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_rank", 32'(rank), 32'd0);
    reset = 1'b0;

    // Not placed, tie at the bottom, middle insert, new top score.
    go(32'd50);   wait_done();
    go(32'd500);  wait_done();
    go(32'd700);  wait_done();
    go(32'd1000); wait_done();

    // Start pulsed while busy is ignored.
    go(32'd800);
    @(negedge clk); @(negedge clk);
    new_score = 32'd5000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    // Reset during the first write of a shift.
    @(negedge clk);
    new_score = 32'd2000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w.a = 2'd2;
    w.d = model[1];
    wq.push_back(w);
    model[2] = model[1];
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (we !== 1'b1 && n < 20);
    chk("rst_reach_write", 32'(we), 32'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_cs", 32'(cs), 32'd0);
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_done_wr", 32'(done_wr), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_wq_empty", 32'(wq.size()), 32'd0);
    go(32'd950); wait_done();

    // Start held high: two back-to-back runs, the second sees the first's table.
    @(negedge clk);
    new_score = 32'd1200;
    start = 1'b1;
    @(posedge clk); #1;
    e1 = cyc;
    push_run(32'd1200, e1, l1);
    e2 = e1 + l1 + 1;
    push_run(32'd1200, e2, l2);
    n = 0;
    while (cyc != e2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("b2b_bound", 32'(n < 40), 32'd1);
    wait_done();
    repeat (8) @(negedge clk);
    chk("final_wq_empty", 32'(wq.size()), 32'd0);
    chk("final_dq_empty", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
